// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered result/writeback stage behind the shifter, the ALU and the
// sequential multiplier. It takes one decoded operation per handshake,
// selects its 32-bit result, and runs the MULTU start/wait/capture sequence
// that fills the HI/LO pair.
//
// Handshake: an operation is taken on a rising edge only when in_valid and
// in_ready are both high at that edge. in_ready depends only on state and
// reset, never on in_valid. Outputs carry no ready. out_valid is a one-cycle
// pulse that marks a dataOut update, and dataOut holds between updates.
module alu_result_stage #(
    parameter int MUL_TIMEOUT = 40,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Signal,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] shift_result,
    input  logic [63:0] mul_product,
    input  logic        mul_done,
    output logic        mul_start,
    output logic [31:0] dataOut,
    output logic        out_valid,
    output logic        mul_err,
    output logic        o_dbg_state
);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // Counter value on the final allowed MUL_WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic [31:0]       r_data;
    logic              r_out_valid;
    logic              r_mul_start;
    logic              r_mul_err;

    logic              w_accept;
    logic              w_is_multu;
    logic [31:0]       w_sel_data;
    logic              w_timeout;
    logic              w_capture;

    assign in_ready    = (r_state == ST_IDLE) && !reset;
    assign w_accept    = in_valid && in_ready;
    assign w_is_multu  = (Signal == F_MULTU);

    // A done pulse always wins over the timeout on the same cycle.
    assign w_capture   = (r_state == ST_MUL_WAIT) && mul_done;
    assign w_timeout   = (r_state == ST_MUL_WAIT) && !mul_done && (r_count == CNT_LAST);

    assign dataOut     = r_data;
    assign out_valid   = r_out_valid;
    assign mul_start   = r_mul_start;
    assign mul_err     = r_mul_err;
    assign o_dbg_state = (r_state == ST_MUL_WAIT);

    // Result select for the offered funct code. Unknown codes give zero.
    always_comb begin
        w_sel_data = 32'h0;
        case (Signal)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: w_sel_data = alu_result;
            F_SRL:                            w_sel_data = shift_result;
            F_MFHI:                           w_sel_data = r_hi;
            F_MFLO:                           w_sel_data = r_lo;
            default:                          w_sel_data = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: enter MUL_WAIT on MULTU, leave it on done or timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_multu) begin
                    w_state_next = ST_MUL_WAIT;
                end
            end
            ST_MUL_WAIT: begin
                if (w_capture || w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Wait counter: cleared on MULTU accept, counts every cycle in MUL_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept && w_is_multu) begin
            r_count <= '0;
        end else if (r_state == ST_MUL_WAIT) begin
            r_count <= r_count + 1'b1;
        end
    end

    // HI/LO capture. It happens only on a done pulse while waiting, so a stray done in IDLE is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'h0;
            r_lo <= 32'h0;
        end else if (w_capture) begin
            r_hi <= mul_product[63:32];
            r_lo <= mul_product[31:0];
        end
    end

    // Multiplier start pulse and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_start <= 1'b0;
            r_mul_err   <= 1'b0;
        end else begin
            r_mul_start <= w_accept && w_is_multu;
            if (w_accept && w_is_multu) begin
                r_mul_err <= 1'b0;
            end else if (w_timeout) begin
                r_mul_err <= 1'b1;
            end
        end
    end

    // Registered writeback. Every accepted op except MULTU produces a result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= 32'h0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_accept && !w_is_multu;
            if (w_accept && !w_is_multu) begin
                r_data <= w_sel_data;
            end
        end
    end

endmodule
